word_assembler: RTL and testbench

Consumer end of the character-generator stream. Collects per-position character writes (offset/value pairs) into a working word buffer and, on each word-complete strobe, snapshots the word into a one-entry output slot with a ready/valid handshake toward the hashing pipeline (PBKDF2/SHA1 front end). It back-pressures the generator through `advance_next` and reports end-of-keyspace once the last word has drained.

---
 rtl/word_assembler_if.sv | 32 +++
 rtl/word_assembler.sv | 137 +++++++++++++
 tb/tb_word_assembler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/word_assembler_if.sv
// Generator-to-hash handshake bundle: character writes and word strobes in, word slot out.
// The master drives the generator-side inputs and out_ready; the slave is the assembler.
interface word_assembler_if #(
  parameter int MAX_CHARS = 16,
  parameter int CW        = 7
);
  logic                   char_wr;
  logic [3:0]             char_offset;
  logic [CW-1:0]          char_value;
  logic                   word_valid;
  logic [31:0]            word_counter;
  logic                   finished;
  logic                   advance_next;
  logic [8*MAX_CHARS-1:0] out_word;
  logic [4:0]             out_len;
  logic [31:0]            out_index;
  logic                   out_valid;
  logic                   out_ready;
  logic                   done;
  logic                   overflow;
  logic                   bad_offset;

  modport master (
    output char_wr, char_offset, char_value, word_valid, word_counter, finished, out_ready,
    input  advance_next, out_word, out_len, out_index, out_valid, done, overflow, bad_offset
  );

  modport slave (
    input  char_wr, char_offset, char_value, word_valid, word_counter, finished, out_ready,
    output advance_next, out_word, out_len, out_index, out_valid, done, overflow, bad_offset
  );
endinterface

// File: rtl/word_assembler.sv
// Collects offset/value character writes into a word and snapshots it into a one-entry output slot.
// Latency: char write -> buffer 1 cycle; word_valid -> out_valid 1 cycle, same-cycle writes bypassed.
// Backpressure: advance_next drops while the slot is full and not accepted; a word arriving then is dropped.
module word_assembler #(
  parameter int MAX_CHARS = 16,
  parameter int CW        = 7
) (
  input logic            clk,
  input logic            reset,
  word_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [4:0] MAX_L = 5'(MAX_CHARS);

  state_t state, state_nxt;

  logic [7:0]             wbuf [MAX_CHARS];
  logic [4:0]             wlen;
  logic [7:0]             nbuf [MAX_CHARS];
  logic [4:0]             nlen;
  logic [4:0]             wr_len;
  logic [8*MAX_CHARS-1:0] nword;

  logic in_collect;
  logic slot_free;
  logic accept;
  logic offset_ok;
  logic wr_ok;
  logic load;
  logic drop;

  assign in_collect = (state == COLLECT);
  assign slot_free  = !bus.out_valid || bus.out_ready;
  assign accept     = bus.out_valid && bus.out_ready;
  assign offset_ok  = ({1'b0, bus.char_offset} < MAX_L);
  assign wr_ok      = in_collect && bus.char_wr && offset_ok;
  assign load       = in_collect && bus.word_valid && slot_free;
  assign drop       = in_collect && bus.word_valid && !slot_free;
  assign wr_len     = {1'b0, bus.char_offset} + 5'd1;

  // Buffer as it will look after this cycle's write; the snapshot reads this so a
  // write coinciding with word_valid lands in the captured word.
  always_comb begin
    nlen  = wlen;
    nword = '0;
    if (wr_ok && (wr_len > wlen)) begin
      nlen = wr_len;
    end
    for (int i = 0; i < MAX_CHARS; i++) begin
      nbuf[i] = wbuf[i];
      if (wr_ok && (bus.char_offset == 4'(i))) begin
        nbuf[i] = 8'(bus.char_value);
      end
      nword[8*i +: 8] = (5'(i) < nlen) ? nbuf[i] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        wbuf[i] <= 8'h00;
      end
      wlen <= 5'd0;
    end else begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        wbuf[i] <= nbuf[i];
      end
      wlen <= nlen;
    end
  end

  // Output slot: a load wins over a simultaneous accept, keeping out_valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_word   <= '0;
      bus.out_len    <= 5'd0;
      bus.out_index  <= 32'd0;
      bus.out_valid  <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.bad_offset <= 1'b0;
    end else begin
      if (load) begin
        bus.out_word  <= nword;
        bus.out_len   <= nlen;
        bus.out_index <= bus.word_counter;
        bus.out_valid <= 1'b1;
      end else if (accept) begin
        bus.out_valid <= 1'b0;
      end
      if (drop) begin
        bus.overflow <= 1'b1;
      end
      if (in_collect && bus.char_wr && !offset_ok) begin
        bus.bad_offset <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // With nothing in flight at finish, skip DRAIN so done follows finished by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (bus.finished) begin
          state_nxt = (!load && slot_free) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.advance_next = in_collect && slot_free;
    bus.done         = (state == DONE);
  end

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler (MAX_CHARS = 8); accepted words are scored against a queue.
module tb_word_assembler;
  localparam int MC = 8;
  localparam int CW = 7;

  typedef struct packed {
    logic [8*MC-1:0] word;
    logic [4:0]      len;
    logic [31:0]     idx;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_assembler_if #(.MAX_CHARS(MC), .CW(CW)) bus ();

  word_assembler #(.MAX_CHARS(MC), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sbq[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [8*MC-1:0] w, input logic [4:0] l, input logic [31:0] ix);
    exp_t e;
    e.word = w;
    e.len  = l;
    e.idx  = ix;
    return e;
  endfunction

  // Monitor: handshake is stable at the falling edge and completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got index %0d, expected no word", bus.out_index);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_word",  64'(bus.out_word),  64'(mon_e.word));
        check("sb_len",   64'(bus.out_len),   64'(mon_e.len));
        check("sb_index", 64'(bus.out_index), 64'(mon_e.idx));
      end
    end
  end

  task automatic step(input logic wr, input logic [3:0] off, input logic [CW-1:0] val,
                      input logic wv, input logic [31:0] cnt);
    bus.char_wr      = wr;
    bus.char_offset  = off;
    bus.char_value   = val;
    bus.word_valid   = wv;
    bus.word_counter = cnt;
    @(posedge clk);
    #1;
    bus.char_wr    = 1'b0;
    bus.word_valid = 1'b0;
  endtask

  initial begin
    bus.char_wr      = 1'b0;
    bus.char_offset  = 4'd0;
    bus.char_value   = '0;
    bus.word_valid   = 1'b0;
    bus.word_counter = 32'd0;
    bus.finished     = 1'b0;
    bus.out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_word",   64'(bus.out_word),   64'd0);
    check("rst_out_len",    64'(bus.out_len),    64'd0);
    check("rst_out_index",  64'(bus.out_index),  64'd0);
    check("rst_flags",      64'({bus.done, bus.overflow, bus.bad_offset}), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_advance",    64'(bus.advance_next), 64'd1);

    // Basic word with bypass on the third write.
    step(1'b1, 4'd0, 7'h61, 1'b0, 32'd0);
    step(1'b1, 4'd1, 7'h62, 1'b0, 32'd0);
    sbq.push_back(mk(64'h636261, 5'd3, 32'd5));
    step(1'b1, 4'd2, 7'h63, 1'b1, 32'd5);
    check("basic_valid",    64'(bus.out_valid),    64'd1);
    check("basic_advance",  64'(bus.advance_next), 64'd1);
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
    check("basic_cleared",  64'(bus.out_valid),    64'd0);

    // Odometer: only position 0 changes.
    sbq.push_back(mk(64'h636264, 5'd3, 32'd6));
    step(1'b1, 4'd0, 7'h64, 1'b1, 32'd6);
    check("odo_len",        64'(bus.out_len),      64'd3);
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);

    // Streaming, one word per cycle.
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(mk(64'h636264, 5'd3, 32'(i)));
      step(1'b0, 4'd0, 7'h00, 1'b1, 32'(i));
      check("stream_index", 64'(bus.out_index), 64'(i));
      check("stream_valid", 64'(bus.out_valid), 64'd1);
    end
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
    check("stream_overflow", 64'(bus.overflow), 64'd0);

    // Back-pressure and drop.
    bus.out_ready = 1'b0;
    sbq.push_back(mk(64'h636264, 5'd3, 32'd40));
    step(1'b0, 4'd0, 7'h00, 1'b1, 32'd40);
    check("bp_valid",       64'(bus.out_valid),    64'd1);
    check("bp_advance",     64'(bus.advance_next), 64'd0);
    step(1'b1, 4'd1, 7'h65, 1'b1, 32'd41);
    check("bp_overflow",    64'(bus.overflow),     64'd1);
    check("bp_kept_index",  64'(bus.out_index),    64'd40);
    check("bp_kept_word",   64'(bus.out_word),     64'h636264);
    bus.out_ready = 1'b1;
    #1;
    check("bp_advance_rdy", 64'(bus.advance_next), 64'd1);
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
    check("bp_cleared",     64'(bus.out_valid),    64'd0);

    // End of keyspace with a full slot held for three cycles.
    bus.out_ready = 1'b0;
    sbq.push_back(mk(64'h636564, 5'd3, 32'd50));
    step(1'b0, 4'd0, 7'h00, 1'b1, 32'd50);
    bus.finished = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
      check("drain_done",    64'(bus.done),         64'd0);
      check("drain_advance", 64'(bus.advance_next), 64'd0);
    end
    bus.out_ready = 1'b1;
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
    check("end_done",       64'(bus.done),         64'd1);
    check("end_slot_empty", 64'(bus.out_valid),    64'd0);
    bus.finished = 1'b0;
    step(1'b1, 4'd3, 7'h7a, 1'b1, 32'd60);
    step(1'b1, 4'd4, 7'h7a, 1'b1, 32'd61);
    check("end_no_output",  64'(bus.out_valid),    64'd0);
    check("end_sticky",     64'(bus.done),         64'd1);

    // Bad offset after a fresh reset.
    reset = 1'b1;
    #1;
    check("rst2_done",      64'(bus.done),         64'd0);
    reset = 1'b0;
    step(1'b1, 4'd15, 7'h7a, 1'b0, 32'd0);
    check("bad_offset",     64'(bus.bad_offset),   64'd1);
    sbq.push_back(mk(64'h0, 5'd0, 32'd20));
    step(1'b0, 4'd0, 7'h00, 1'b1, 32'd20);
    check("bad_len",        64'(bus.out_len),      64'd0);
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);

    // Reset mid-word discards the partial buffer.
    step(1'b1, 4'd0, 7'h70, 1'b0, 32'd0);
    step(1'b1, 4'd1, 7'h71, 1'b0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_flags",  64'({bus.bad_offset, bus.overflow, bus.done, bus.out_valid}), 64'd0);
    check("mid_rst_word",   64'(bus.out_word),     64'd0);
    check("mid_rst_index",  64'(bus.out_index),    64'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_advance", 64'(bus.advance_next), 64'd1);
    sbq.push_back(mk(64'h72, 5'd1, 32'd21));
    step(1'b1, 4'd0, 7'h72, 1'b1, 32'd21);
    check("fresh_len",      64'(bus.out_len),      64'd1);
    step(1'b0, 4'd0, 7'h00, 1'b0, 32'd0);
    check("queue_drained",  64'(sbq.size()),       64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
